// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// Holds the FSM state enum and the counter/retry width functions.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_seq_state_e;

   // Width of the shared sequencing counter: wide enough for the
   // largest terminal value, never narrower than one bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic int retry_width(input int r);
      return (r > 0) ? $clog2(r + 1) : 1;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses PLL reset, qualifies LOCK, gates sys reset.
// Ports: clk, rst_n, pll_lock_i, relock_req_i -> pll_rst_o, sys_rst_n_o,
// ready_o, fail_o, retry_cnt_o; loss_cnt_o with PLL_LOCK_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 270000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_lock_i,
   input  logic relock_req_i,
   output logic pll_rst_o,
   output logic sys_rst_n_o,
   output logic ready_o,
   output logic fail_o,
   output logic [retry_width(MAX_RETRIES)-1:0] retry_cnt_o
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
   ,
   output logic [7:0] loss_cnt_o
`endif
);

   localparam int CNT_W = cnt_width(PLL_RST_CYCLES,
                                    LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES);
   localparam int RC_W = retry_width(MAX_RETRIES);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   // The WAIT_LOCK cycle that sees lock already counts as the first
   // stable cycle, so STABLE itself needs one cycle fewer.
   localparam logic [CNT_W-1:0] ST_LAST  = (LOCK_STABLE_CYCLES > 1) ?
      CNT_W'(LOCK_STABLE_CYCLES - 2) : '0;
   localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRIES);

   pll_seq_state_e   state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [RC_W-1:0]  retry_d;
   logic             lock_s;
   logic             fail_att;
   logic             lost_run;

   sync2 u_lock_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (pll_lock_i),
      .q    (lock_s)
   );

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      retry_d  = retry_cnt_o;
      fail_att = 1'b0;
      lost_run = 1'b0;
      if (relock_req_i) begin
         state_d = PLL_RST;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state)
            PLL_RST: begin
               if (cnt == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt == TO_LAST) begin
                  fail_att = 1'b1;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  fail_att = 1'b1;
               end else if (cnt == ST_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (!lock_s) begin
                  fail_att = 1'b1;
                  lost_run = 1'b1;
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end
         endcase
         if (fail_att) begin
            cnt_d = '0;
            if (retry_cnt_o < RC_MAX) begin
               retry_d = retry_cnt_o + RC_W'(1);
               state_d = PLL_RST;
            end else begin
               state_d = FAIL;
            end
         end
      end
   end

   // Outputs are registered from the next state so they always
   // match the state register in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= PLL_RST;
         cnt         <= '0;
         retry_cnt_o <= '0;
         pll_rst_o   <= 1'b1;
         sys_rst_n_o <= 1'b0;
         ready_o     <= 1'b0;
         fail_o      <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         retry_cnt_o <= retry_d;
         pll_rst_o   <= (state_d == PLL_RST) || (state_d == FAIL);
         sys_rst_n_o <= (state_d == RUN);
         ready_o     <= (state_d == RUN);
         fail_o      <= (state_d == FAIL);
      end
   end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
   // Counts only lock losses that restart the sequence, not those
   // that exhaust the retries; survives relock requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt_o <= '0;
      end else if (lost_run && state_d == PLL_RST &&
                   loss_cnt_o != 8'hFF) begin
         loss_cnt_o <= loss_cnt_o + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer, small parameter set.
// Expected values are queued at stimulus time and popped at observation.
module tb_pll_lock_sequencer;

   localparam int PR = 4;
   localparam int TO = 50;
   localparam int ST = 8;
   localparam int MR = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic pll_lock_i;
   logic relock_req_i;
   logic pll_rst_o;
   logic sys_rst_n_o;
   logic ready_o;
   logic fail_o;
   logic [1:0] retry_cnt_o;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
   logic [7:0] loss_cnt_o;
`endif

   int total = 0;
   int bad = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES     (PR),
      .LOCK_TIMEOUT_CYCLES(TO),
      .LOCK_STABLE_CYCLES (ST),
      .MAX_RETRIES        (MR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_lock_i  (pll_lock_i),
      .relock_req_i(relock_req_i),
      .pll_rst_o   (pll_rst_o),
      .sys_rst_n_o (sys_rst_n_o),
      .ready_o     (ready_o),
      .fail_o      (fail_o),
      .retry_cnt_o (retry_cnt_o)
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      ,
      .loss_cnt_o  (loss_cnt_o)
`endif
   );

   // Counts consecutive negedges where pll_rst_o equals lvl (FAIL stops it).
   task automatic count_rst(input logic lvl, output int n);
      n = 0;
      while (pll_rst_o === lvl && fail_o === 1'b0 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic relock_pulse(input logic lock);
      pll_lock_i   = lock;
      relock_req_i = 1'b1;
      @(negedge clk);
      relock_req_i = 1'b0;
   endtask

   task automatic test_reset;
      int e;
      rst_n = 1'b0;
      pll_lock_i = 1'b0;
      relock_req_i = 1'b0;
      exp_q.push_back(1);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(0);
      repeat (3) @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (pll_rst_o !== e) begin bad++;
         $display("FAIL rst_pll_rst: got %b want %0d", pll_rst_o, e); end
      e = exp_q.pop_front(); total++;
      if (sys_rst_n_o !== e) begin bad++;
         $display("FAIL rst_sys_rst_n: got %b want %0d", sys_rst_n_o, e); end
      e = exp_q.pop_front(); total++;
      if (ready_o !== e) begin bad++;
         $display("FAIL rst_ready: got %b want %0d", ready_o, e); end
      e = exp_q.pop_front(); total++;
      if (fail_o !== e) begin bad++;
         $display("FAIL rst_fail: got %b want %0d", fail_o, e); end
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL rst_retry: got %0d want %0d", retry_cnt_o, e); end
   endtask

   task automatic test_nominal;
      int e, n, k;
      exp_q.push_back(PR);
      exp_q.push_back(2 + ST);
      exp_q.push_back(1);
      exp_q.push_back(0);
      rst_n = 1'b1;
      count_rst(1'b1, n);
      e = exp_q.pop_front(); total++;
      if (n !== e) begin bad++;
         $display("FAIL nom_rst_pulse: got %0d want %0d", n, e); end
      repeat (10 - PR) @(negedge clk);
      pll_lock_i = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end
      while (sys_rst_n_o !== 1'b1 && k < 100);
      e = exp_q.pop_front(); total++;
      if (k !== e) begin bad++;
         $display("FAIL nom_lock_to_rel: got %0d want %0d", k, e); end
      e = exp_q.pop_front(); total++;
      if (ready_o !== e) begin bad++;
         $display("FAIL nom_ready: got %b want %0d", ready_o, e); end
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL nom_retry: got %0d want %0d", retry_cnt_o, e); end
   endtask

   task automatic test_loss_run;
      int e, n, k;
      exp_q.push_back(3);
      exp_q.push_back(PR);
      exp_q.push_back(1);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      exp_q.push_back(1);
`endif
      exp_q.push_back(1);
      pll_lock_i = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end
      while (sys_rst_n_o !== 1'b0 && k < 100);
      e = exp_q.pop_front(); total++;
      if (k !== e) begin bad++;
         $display("FAIL loss_sys_fall: got %0d want %0d", k, e); end
      pll_lock_i = 1'b1;
      count_rst(1'b1, n);
      e = exp_q.pop_front(); total++;
      if (n !== e) begin bad++;
         $display("FAIL loss_rst_pulse: got %0d want %0d", n, e); end
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL loss_retry: got %0d want %0d", retry_cnt_o, e); end
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      e = exp_q.pop_front(); total++;
      if (loss_cnt_o !== e) begin bad++;
         $display("FAIL loss_cnt: got %0d want %0d", loss_cnt_o, e); end
`endif
      k = 0;
      while (ready_o !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      e = exp_q.pop_front(); total++;
      if (ready_o !== e) begin bad++;
         $display("FAIL loss_rerun: got %b want %0d", ready_o, e); end
   endtask

   task automatic test_glitch_stable;
      int e, m;
      logic rose;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(1);
      exp_q.push_back(0);
      relock_pulse(1'b1);
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL gl_relock_retry: got %0d want %0d", retry_cnt_o, e); end
      m = 0;
      while (pll_rst_o === 1'b1 && m < 50) begin @(negedge clk); m++; end
      // In WAIT_LOCK with lock_s high; STABLE count 5 is 6 edges on.
      repeat (4) @(negedge clk);
      pll_lock_i = 1'b0;
      @(negedge clk);
      pll_lock_i = 1'b1;
      rose = 1'b0;
      m = 0;
      while (pll_rst_o !== 1'b1 && m < 20) begin
         if (sys_rst_n_o === 1'b1) rose = 1'b1;
         @(negedge clk);
         m++;
      end
      e = exp_q.pop_front(); total++;
      if (pll_rst_o !== e) begin bad++;
         $display("FAIL gl_back_to_rst: got %b want %0d", pll_rst_o, e); end
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL gl_retry: got %0d want %0d", retry_cnt_o, e); end
      e = exp_q.pop_front(); total++;
      if (rose !== e) begin bad++;
         $display("FAIL gl_sys_rose: got %b want %0d", rose, e); end
   endtask

   task automatic test_never_lock;
      int e, n, w;
      relock_pulse(1'b0);
      for (int a = 0; a <= MR; a++) begin
         exp_q.push_back(PR);
         exp_q.push_back(TO);
         exp_q.push_back((a < MR) ? a + 1 : MR);
         exp_q.push_back((a == MR) ? 1 : 0);
         count_rst(1'b1, n);
         e = exp_q.pop_front(); total++;
         if (n !== e) begin bad++;
            $display("FAIL nl_rst_pulse%0d: got %0d want %0d", a, n, e); end
         count_rst(1'b0, w);
         e = exp_q.pop_front(); total++;
         if (w !== e) begin bad++;
            $display("FAIL nl_wait%0d: got %0d want %0d", a, w, e); end
         e = exp_q.pop_front(); total++;
         if (retry_cnt_o !== e) begin bad++;
            $display("FAIL nl_retry%0d: got %0d want %0d", a, retry_cnt_o, e); end
         e = exp_q.pop_front(); total++;
         if (fail_o !== e) begin bad++;
            $display("FAIL nl_fail%0d: got %b want %0d", a, fail_o, e); end
      end
      exp_q.push_back(1);
      exp_q.push_back(1);
      repeat (60) @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (fail_o !== e) begin bad++;
         $display("FAIL nl_stay_fail: got %b want %0d", fail_o, e); end
      e = exp_q.pop_front(); total++;
      if (pll_rst_o !== e) begin bad++;
         $display("FAIL nl_fail_pll_rst: got %b want %0d", pll_rst_o, e); end
   endtask

   task automatic test_relock_fail;
      int e, k;
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(1);
      relock_pulse(1'b1);
      e = exp_q.pop_front(); total++;
      if (fail_o !== e) begin bad++;
         $display("FAIL rf_fail: got %b want %0d", fail_o, e); end
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL rf_retry: got %0d want %0d", retry_cnt_o, e); end
      e = exp_q.pop_front(); total++;
      if (pll_rst_o !== e) begin bad++;
         $display("FAIL rf_pll_rst: got %b want %0d", pll_rst_o, e); end
      k = 0;
      while (ready_o !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      e = exp_q.pop_front(); total++;
      if (ready_o !== e) begin bad++;
         $display("FAIL rf_run: got %b want %0d", ready_o, e); end
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      exp_q.push_back(1);
      e = exp_q.pop_front(); total++;
      if (loss_cnt_o !== e) begin bad++;
         $display("FAIL rf_loss_kept: got %0d want %0d", loss_cnt_o, e); end
`endif
   endtask

   task automatic test_relock_timeout;
      int e, m;
      exp_q.push_back(0);
      exp_q.push_back(1);
      relock_pulse(1'b0);
      m = 0;
      while (pll_rst_o === 1'b1 && m < 50) begin @(negedge clk); m++; end
      // Now at WAIT_LOCK count 0; the timeout cycle is TO-1 later.
      repeat (TO - 1) @(negedge clk);
      relock_pulse(1'b0);
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL rt_retry: got %0d want %0d", retry_cnt_o, e); end
      e = exp_q.pop_front(); total++;
      if (pll_rst_o !== e) begin bad++;
         $display("FAIL rt_pll_rst: got %b want %0d", pll_rst_o, e); end
   endtask

   task automatic test_back_to_back;
      int e, n;
      exp_q.push_back(PR);
      repeat (2) @(negedge clk);
      relock_pulse(1'b0);
      count_rst(1'b1, n);
      e = exp_q.pop_front(); total++;
      if (n !== e) begin bad++;
         $display("FAIL b2b_restart: got %0d want %0d", n, e); end
   endtask

   task automatic test_async_reset;
      int e, m;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(0);
      exp_q.push_back(0);
      relock_pulse(1'b1);
      m = 0;
      while (pll_rst_o === 1'b1 && m < 50) begin @(negedge clk); m++; end
      repeat (3) @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (pll_rst_o !== e) begin bad++;
         $display("FAIL ar_in_stable: got %b want %0d", pll_rst_o, e); end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      e = exp_q.pop_front(); total++;
      if (pll_rst_o !== e) begin bad++;
         $display("FAIL ar_pll_rst: got %b want %0d", pll_rst_o, e); end
      e = exp_q.pop_front(); total++;
      if (sys_rst_n_o !== e) begin bad++;
         $display("FAIL ar_sys_rst_n: got %b want %0d", sys_rst_n_o, e); end
      e = exp_q.pop_front(); total++;
      if (retry_cnt_o !== e) begin bad++;
         $display("FAIL ar_retry: got %0d want %0d", retry_cnt_o, e); end
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      exp_q.push_back(0);
      e = exp_q.pop_front(); total++;
      if (loss_cnt_o !== e) begin bad++;
         $display("FAIL ar_loss_cnt: got %0d want %0d", loss_cnt_o, e); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_nominal;
      test_loss_run;
      test_glitch_stable;
      test_never_lock;
      test_relock_fail;
      test_relock_timeout;
      test_back_to_back;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
